// File: rtl/pc_gen_if.sv
// Fetch-address handshake bundle between the redirect/stall logic, pc_gen and the IF stage.
// The master side is the address generator; the slave side is its environment.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [1:0]      stall;
    logic            flush_valid;
    logic [XLEN-1:0] flush_target;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            req_ready_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;

    modport master (
        input  stall, flush_valid, flush_target, br_valid, br_target, req_ready_i,
        output pc_o, pc_valid_o, misalign_o
    );

    modport slave (
        output stall, flush_valid, flush_target, br_valid, br_target, req_ready_i,
        input  pc_o, pc_valid_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential stepping, flush/branch redirects with fixed priority,
// and a one-entry buffer that holds redirects arriving while the front end is stalled.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              INST_BYTES = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [1:0] ST_PASS = 2'b00;
    localparam logic [1:0] ST_BUBB = 2'b10;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pend_v;
    logic            r_pend_flush;
    logic [XLEN-1:0] r_pend_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_VEC;
            r_pend_v     <= 1'b0;
            r_pend_flush <= 1'b0;
            r_pend_tgt   <= '0;
        end else if (bus.stall == ST_PASS) begin
            if (bus.flush_valid || bus.br_valid || r_pend_v) begin
                // A redirect replaces any offered-but-unaccepted request.
                if (bus.flush_valid)   r_pc <= bus.flush_target;
                else if (bus.br_valid) r_pc <= bus.br_target;
                else                   r_pc <= r_pend_tgt;
                r_state      <= ISSUE;
                r_pend_v     <= 1'b0;
                r_pend_flush <= 1'b0;
            end else if (r_state == ISSUE) begin
                if (bus.req_ready_i) r_pc <= r_pc + STEP;
            end else begin
                // Re-issue the bubbled address rather than skipping it.
                r_state <= ISSUE;
            end
        end else begin
            if (bus.stall == ST_BUBB) r_state <= IDLE;
            // A pending flush makes any later branch wrong-path, so it is dropped.
            if (bus.flush_valid) begin
                r_pend_tgt   <= bus.flush_target;
                r_pend_v     <= 1'b1;
                r_pend_flush <= 1'b1;
            end else if (bus.br_valid && !r_pend_flush) begin
                r_pend_tgt <= bus.br_target;
                r_pend_v   <= 1'b1;
            end
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_valid_o = (r_state == ISSUE);
    assign bus.misalign_o = !rst && (r_state == ISSUE) && (|(r_pc & ALIGN_MASK));
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written reset/pending sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pc_gen;
    localparam int XLEN = 32;
    localparam int IB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(.XLEN(XLEN), .RESET_VEC(32'h0), .INST_BYTES(IB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural address/valid plus a list of waiting redirects (at most one).
    typedef struct {
        logic [31:0] tgt;
        bit          is_flush;
    } redir_t;

    logic [31:0] m_pc;
    bit          m_valid;
    redir_t      m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [1:0] st, input bit fv, input logic [31:0] ft,
                              input bit bv, input logic [31:0] bt, input bit rdy);
        redir_t e;
        if (r) begin
            m_pc = 32'h0;
            m_valid = 0;
            m_pend.delete();
        end else if (st == 2'b00) begin
            if (fv) begin
                m_pc = ft; m_valid = 1; m_pend.delete();
            end else if (bv) begin
                m_pc = bt; m_valid = 1; m_pend.delete();
            end else if (m_pend.size() != 0) begin
                m_pc = m_pend[0].tgt; m_valid = 1; m_pend.delete();
            end else if (m_valid && rdy) begin
                m_pc = m_pc + 32'(IB);
            end else begin
                m_valid = 1;
            end
        end else begin
            if (st == 2'b10) m_valid = 0;
            if (fv) begin
                e.tgt = ft; e.is_flush = 1;
                m_pend.delete(); m_pend.push_back(e);
            end else if (bv && !(m_pend.size() != 0 && m_pend[0].is_flush)) begin
                e.tgt = bt; e.is_flush = 0;
                m_pend.delete(); m_pend.push_back(e);
            end
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare DUT against it.
    task automatic cyc(input bit r, input logic [1:0] st, input bit fv, input logic [31:0] ft,
                       input bit bv, input logic [31:0] bt, input bit rdy);
        rst = r;
        bus.stall = st;
        bus.flush_valid = fv;
        bus.flush_target = ft;
        bus.br_valid = bv;
        bus.br_target = bt;
        bus.req_ready_i = rdy;
        @(posedge clk);
        model_step(r, st, fv, ft, bv, bt, rdy);
        #1;
        check("model_pc", bus.pc_o, m_pc);
        check("model_valid", 32'(bus.pc_valid_o), 32'(m_valid));
        check("model_misalign", 32'(bus.misalign_o),
              32'(!r && m_valid && ((m_pc % IB) != 0)));
    endtask

    typedef struct {
        logic [1:0]  st;
        bit          fv;
        logic [31:0] ft;
        bit          bv;
        logic [31:0] bt;
        bit          rdy;
        logic [31:0] exp_pc;
        bit          exp_v;
        bit          exp_mis;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic [1:0] st, input bit fv, input logic [31:0] ft, input bit bv,
                        input logic [31:0] bt, input bit rdy, input logic [31:0] ep, input bit ev,
                        input bit em);
        vec_t v;
        v.st = st; v.fv = fv; v.ft = ft; v.bv = bv; v.bt = bt; v.rdy = rdy;
        v.exp_pc = ep; v.exp_v = ev; v.exp_mis = em;
        vt.push_back(v);
    endtask

    initial begin
        bus.stall = 2'b00;
        bus.flush_valid = 0;
        bus.flush_target = '0;
        bus.br_valid = 0;
        bus.br_target = '0;
        bus.req_ready_i = 0;

        // Reset state, including misalign_o held low while rst is high.
        cyc(1, 2'b00, 0, 0, 0, 0, 1);
        cyc(1, 2'b00, 0, 0, 0, 0, 1);
        check("reset_pc", bus.pc_o, 32'h0);
        check("reset_valid", 32'(bus.pc_valid_o), 32'h0);
        check("reset_misalign", 32'(bus.misalign_o), 32'h0);

        //   st     fv ft            bv bt            rdy exp_pc        v  mis
        addv(2'b00, 0, 0,            0, 0,            1, 32'h0,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h4,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h8,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            0, 32'h8,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            0, 32'h8,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            0, 32'h8,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'hC,        1, 0);
        addv(2'b01, 0, 0,            1, 32'h100,      1, 32'hC,        1, 0);
        addv(2'b01, 0, 0,            0, 0,            1, 32'hC,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h100,      1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h104,      1, 0);
        addv(2'b00, 1, 32'h80,       1, 32'h200,      1, 32'h80,       1, 0);
        addv(2'b01, 1, 32'h80,       0, 0,            1, 32'h80,       1, 0);
        addv(2'b01, 0, 0,            1, 32'h200,      1, 32'h80,       1, 0);
        addv(2'b00, 0, 0,            0, 0,            0, 32'h80,       1, 0);
        addv(2'b00, 1, 32'h10,       0, 0,            1, 32'h10,       1, 0);
        addv(2'b10, 0, 0,            0, 0,            1, 32'h10,       0, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h10,       1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h14,       1, 0);
        addv(2'b00, 0, 0,            1, 32'h102,      1, 32'h102,      1, 1);
        addv(2'b00, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h0,        1, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h4,        1, 0);
        addv(2'b11, 0, 0,            0, 0,            1, 32'h4,        1, 0);
        addv(2'b10, 0, 0,            1, 32'h40,       1, 32'h4,        0, 0);
        addv(2'b00, 0, 0,            0, 0,            1, 32'h40,       1, 0);
        addv(2'b00, 0, 0,            0, 0,            0, 32'h40,       1, 0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(0, vt[i].st, vt[i].fv, vt[i].ft, vt[i].bv, vt[i].bt, vt[i].rdy);
            check($sformatf("vec%0d_pc", i), bus.pc_o, vt[i].exp_pc);
            check($sformatf("vec%0d_valid", i), 32'(bus.pc_valid_o), 32'(vt[i].exp_v));
            check($sformatf("vec%0d_mis", i), 32'(bus.misalign_o), 32'(vt[i].exp_mis));
        end

        // Reset in the middle of a hold with a flush pending: the pending entry must vanish.
        cyc(0, 2'b01, 1, 32'h300, 0, 0, 1);
        cyc(1, 2'b01, 0, 0, 0, 0, 1);
        cyc(0, 2'b00, 0, 0, 0, 0, 0);
        check("rst_clears_pend_pc", bus.pc_o, 32'h0);
        check("rst_clears_pend_valid", 32'(bus.pc_valid_o), 32'h1);

        // Bubble with a pending flush: later branch is discarded, flush target wins.
        cyc(0, 2'b10, 1, 32'h500, 0, 0, 1);
        cyc(0, 2'b10, 0, 0, 1, 32'h600, 1);
        check("bubb_valid_low", 32'(bus.pc_valid_o), 32'h0);
        cyc(0, 2'b00, 0, 0, 0, 0, 1);
        check("pend_flush_wins_pc", bus.pc_o, 32'h500);
        cyc(0, 2'b00, 0, 0, 0, 0, 1);
        check("after_flush_step", bus.pc_o, 32'h504);

        // Branch pending in HOLD, then overwritten by a later branch: last one wins.
        cyc(0, 2'b01, 0, 0, 1, 32'h700, 1);
        cyc(0, 2'b01, 0, 0, 1, 32'h800, 1);
        cyc(0, 2'b00, 0, 0, 0, 0, 1);
        check("br_overwrite_pc", bus.pc_o, 32'h800);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  st;
            logic [31:0] ft, bt;
            int          r;
            r  = int'($urandom_range(0, 7));
            st = (r < 4) ? 2'b00 : 2'(r - 4);
            ft = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) ft[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            cyc($urandom_range(0, 99) == 0, st, $urandom_range(0, 9) == 0, ft,
                $urandom_range(0, 5) == 0, bt, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
